perceptron_sequencer: RTL and testbench

- Sequenced single-layer perceptron evaluator. Holds N signed 32-bit weights in a local register file and serially accumulates the weights whose binary input bit is set, one input per clock.
- Compares the final sum against a signed threshold and produces a fire decision.
- Sits between the host/training logic and the classifier output. It replaces the combinational weighted sum with a single shared adder scheduled over N cycles.

---
 rtl/perceptron_sequencer.sv | 104 ++++++++++
 tb/tb_perceptron_sequencer.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/perceptron_sequencer.sv
// Sequenced single-layer perceptron: one shared adder walks the N weights,
// adding each weight whose input bit is set, then compares against a threshold.
module perceptron_sequencer #(
  parameter int N  = 8,
  parameter int AW = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [N-1:0]        x,
  input  logic signed [31:0]  threshold,
  input  logic                w_we,
  input  logic [AW-1:0]       w_addr,
  input  logic signed [31:0]  w_data,
  output logic                busy,
  output logic                done,
  output logic signed [31:0]  sum,
  output logic                fire
);

  localparam int            DEPTH = 1 << AW;
  localparam logic [AW:0]   N_EXT = (AW+1)'(N);
  localparam logic [AW-1:0] LAST  = AW'(N-1);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t               state, state_nxt;
  logic [AW-1:0]        idx;
  logic [N-1:0]         x_lat;
  logic signed [31:0]   thr_lat;
  logic signed [31:0]   acc;
  logic signed [31:0]   w [DEPTH];
  logic                 wr_ok;

  // Two's-complement add; overflow wraps modulo 2^32.
  function automatic logic signed [31:0] wrap_add(input logic signed [31:0] a,
                                                  input logic signed [31:0] b);
    return a + b;
  endfunction

  function automatic logic fire_of(input logic signed [31:0] s,
                                   input logic signed [31:0] t);
    return s > t;
  endfunction

  assign wr_ok = w_we && ({1'b0, w_addr} < N_EXT);
  assign busy  = (state == ACCUM);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ACCUM;
      ACCUM:   if (idx == LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Weights are only writable in IDLE, so an evaluation sees a frozen set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx     <= '0;
      x_lat   <= '0;
      thr_lat <= '0;
      acc     <= '0;
      sum     <= '0;
      fire    <= 1'b0;
      done    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) w[i] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_ok) w[w_addr] <= w_data;
          if (start) begin
            x_lat   <= x;
            thr_lat <= threshold;
            acc     <= '0;
            idx     <= '0;
          end
        end
        ACCUM: begin
          if (x_lat[idx]) acc <= wrap_add(acc, w[idx]);
          idx <= idx + 1'b1;
        end
        DONE: begin
          sum  <= acc;
          fire <= fire_of(acc, thr_lat);
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_perceptron_sequencer.sv
// Scoreboard bench for perceptron_sequencer: directed evaluations push expected
// results; a monitor checks sum, fire and done timing on every done pulse.
module tb_perceptron_sequencer;
  localparam int N  = 8;
  localparam int AW = 3;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic [N-1:0]       x;
  logic signed [31:0] threshold;
  logic               w_we;
  logic [AW-1:0]      w_addr;
  logic signed [31:0] w_data;
  logic               busy;
  logic               done;
  logic signed [31:0] sum;
  logic               fire;

  perceptron_sequencer #(.N(N), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .x(x), .threshold(threshold),
    .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
    .busy(busy), .done(done), .sum(sum), .fire(fire)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [31:0] s;
    logic               f;
    int                 c;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sum", sum, e.s);
        chk("fire", {31'd0, fire}, {31'd0, e.f});
        chk("done_latency", cyc, e.c);
      end
    end
  end

  task automatic write_w(input logic [AW-1:0] a, input logic signed [31:0] d);
    @(negedge clk);
    w_we = 1'b1; w_addr = a; w_data = d;
    @(negedge clk);
    w_we = 1'b0;
  endtask

  // Start one evaluation; optional same-cycle weight write and optional
  // disturbance (start/write/x change) while the evaluation is running.
  task automatic run_eval(input logic [N-1:0] xv, input logic signed [31:0] thr,
                          input logic signed [31:0] es, input logic ef,
                          input bit wr, input logic [AW-1:0] wa,
                          input logic signed [31:0] wd, input bit disturb);
    exp_t e;
    int   bc;
    int   t;
    @(negedge clk);
    x = xv; threshold = thr; start = 1'b1;
    if (wr) begin w_we = 1'b1; w_addr = wa; w_data = wd; end
    e.s = es; e.f = ef; e.c = cyc + 1 + N + 1;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0; w_we = 1'b0;
    bc = 0; t = 0;
    while (sb.size() != 0 && t < 40) begin
      if (busy) bc++;
      if (disturb && t == 2) begin
        start = 1'b1; w_we = 1'b1; w_addr = 3'd3; w_data = 32'sd100; x = 8'hFF;
      end
      if (disturb && t == 4) begin
        start = 1'b0; w_we = 1'b0;
      end
      @(negedge clk); #1;
      t++;
    end
    if (sb.size() != 0) begin
      chk("done_timeout", 32'd1, 32'd0);
      sb.delete();
    end
    chk("busy_cycles", bc, N);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; x = '0; threshold = '0;
    w_we = 1'b0; w_addr = '0; w_data = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_sum", sum, 32'd0);
    chk("reset_fire", {31'd0, fire}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < N; i++) write_w(AW'(i), 32'(i + 1));
    run_eval(8'hFF, 32'sd30, 32'sd36, 1'b1, 1'b0, '0, '0, 1'b0);
    run_eval(8'b0000_0101, 32'sd4, 32'sd4, 1'b0, 1'b0, '0, '0, 1'b0);

    // Disturbance mid-evaluation must not restart, rewrite w3 or see new x.
    run_eval(8'h0F, 32'sd0, 32'sd10, 1'b1, 1'b0, '0, '0, 1'b1);
    repeat (3) @(negedge clk);
    run_eval(8'h08, 32'sd0, 32'sd4, 1'b1, 1'b0, '0, '0, 1'b0);
    run_eval(8'h08, 32'sd0, 32'sd100, 1'b1, 1'b1, 3'd3, 32'sd100, 1'b0);

    write_w(3'd0, 32'sh7FFF_FFFF);
    write_w(3'd1, 32'sd1);
    for (int i = 2; i < N; i++) write_w(AW'(i), 32'sd0);
    run_eval(8'h03, 32'sd0, 32'sh8000_0000, 1'b0, 1'b0, '0, '0, 1'b0);

    write_w(3'd0, -32'sd5);
    write_w(3'd1, 32'sd2);
    run_eval(8'h00, -32'sd1, 32'sd0, 1'b1, 1'b0, '0, '0, 1'b0);
    run_eval(8'h01, -32'sd1, -32'sd5, 1'b0, 1'b0, '0, '0, 1'b0);

    // Reset at the fourth ACCUM cycle.
    write_w(3'd2, 32'sd7);
    @(negedge clk);
    x = 8'hFF; threshold = 32'sd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_sum", sum, 32'd0);
    chk("midrst_fire", {31'd0, fire}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (N + 4) @(negedge clk);
    run_eval(8'hFF, -32'sd1, 32'sd0, 1'b1, 1'b0, '0, '0, 1'b0);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
